// File: rtl/lab4_sys_mem_net_router_pkg.sv
// Shared types and constants for the N-to-1 16B memory request/response router.
// Holds the 16B memory message formats, the position of the source-id tag inside
// the opaque field, the arbiter FSM state enum and small tag/untag helpers.
package lab4_sys_mem_net_router_pkg;

    localparam int unsigned MEM_TYPE_W   = 3;
    localparam int unsigned MEM_OPAQUE_W = 8;
    localparam int unsigned MEM_ADDR_W   = 32;
    localparam int unsigned MEM_LEN_W    = 4;
    localparam int unsigned MEM_DATA_W   = 128;
    localparam int unsigned MEM_TEST_W   = 2;

    // Source id lives in opaque[7:6]
    localparam int unsigned SRC_ID_W   = 2;
    localparam int unsigned SRC_ID_LSB = 6;
    localparam int unsigned SRC_ID_MSB = SRC_ID_LSB + SRC_ID_W - 1;

    typedef struct packed {
        logic [MEM_TYPE_W-1:0]   msg_type;
        logic [MEM_OPAQUE_W-1:0] opaque;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_LEN_W-1:0]    len;
        logic [MEM_DATA_W-1:0]   data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [MEM_TYPE_W-1:0]   msg_type;
        logic [MEM_OPAQUE_W-1:0] opaque;
        logic [MEM_TEST_W-1:0]   test;
        logic [MEM_LEN_W-1:0]    len;
        logic [MEM_DATA_W-1:0]   data;
    } mem_resp_16B_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Stamp the source id into a request's opaque field
    function automatic mem_req_16B_t tag_req(input mem_req_16B_t m,
                                             input logic [SRC_ID_W-1:0] id);
        mem_req_16B_t r;
        r = m;
        r.opaque[SRC_ID_MSB:SRC_ID_LSB] = id;
        return r;
    endfunction

    // Strip the source id from a response before handing it back to a cache
    function automatic mem_resp_16B_t clear_src(input mem_resp_16B_t m);
        mem_resp_16B_t r;
        r = m;
        r.opaque[SRC_ID_MSB:SRC_ID_LSB] = '0;
        return r;
    endfunction

endpackage

// File: rtl/lab4_sys_mem_net_router_arb.sv
// Round-robin arbiter with a HOLD latch so a stalled grant stays put until it fires.
// Ports: val_i request vector, adv_i merged-stream fire strobe; grant_c_o one-hot
// grant, grant_idx_c_o binary grant, val_c_o granted request valid.
module lab4_sys_mem_net_rr_arb
    import lab4_sys_mem_net_router_pkg::*;
#(
    parameter int unsigned p_num_ports = 4
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_num_ports-1:0] val_i,
    input  logic                   adv_i,
    output logic [p_num_ports-1:0] grant_c_o,
    output logic [SRC_ID_W-1:0]    grant_idx_c_o,
    output logic                   val_c_o
);

    arb_state_e          state_q, state_d;
    logic [SRC_ID_W-1:0] ptr_q, ptr_d;
    logic [SRC_ID_W-1:0] hold_q, hold_d;
    logic [SRC_ID_W-1:0] scan_idx, cand;
    logic                scan_found;

    function automatic logic [SRC_ID_W-1:0] wrap_inc(input logic [SRC_ID_W-1:0] idx);
        if (idx == SRC_ID_W'(p_num_ports - 1)) return '0;
        return idx + SRC_ID_W'(1);
    endfunction

    // First valid port at or after ptr, wrapping
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = ptr_q;
        cand       = ptr_q;
        for (int unsigned k = 0; k < p_num_ports; k++) begin
            if (!scan_found && val_i[cand]) begin
                scan_found = 1'b1;
                scan_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_d        = hold_q;
        grant_idx_c_o = scan_idx;
        val_c_o       = scan_found;
        grant_c_o     = '0;
        if (state_q == HOLD) begin
            grant_idx_c_o = hold_q;
            val_c_o       = val_i[hold_q];
        end
        if (val_c_o) grant_c_o[grant_idx_c_o] = 1'b1;
        case (state_q)
            IDLE: begin
                if (val_c_o && adv_i) begin
                    ptr_d = wrap_inc(grant_idx_c_o);
                end else if (val_c_o) begin
                    hold_d  = grant_idx_c_o;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (val_c_o && adv_i) begin
                    ptr_d   = wrap_inc(hold_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: rtl/lab4_sys_mem_net_router_queue.sv
// Two-entry normal queue (no bypass) placed in front of each arbiter input.
// Ports: enq_* (val/rdy/msg) from the cache, deq_* (val/rdy/msg) to the arbiter.
module lab4_sys_mem_net_router_queue
    import lab4_sys_mem_net_router_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         enq_val_i,
    output logic         enq_rdy_c_o,
    input  mem_req_16B_t enq_msg_i,
    output logic         deq_val_c_o,
    output mem_req_16B_t deq_msg_c_o,
    input  logic         deq_rdy_i
);

    mem_req_16B_t entry_q [2];
    logic         head_q, head_d;
    logic [1:0]   count_q, count_d;
    logic         tail;
    logic         enq_fire, deq_fire;

    assign enq_rdy_c_o = ~count_q[1];
    assign deq_val_c_o = (count_q != 2'd0);
    assign deq_msg_c_o = entry_q[head_q];
    assign enq_fire    = enq_val_i & enq_rdy_c_o;
    assign deq_fire    = deq_val_c_o & deq_rdy_i;
    // With one entry stored the free slot is the one after head
    assign tail        = head_q ^ count_q[0];

    always_comb begin
        head_d  = deq_fire ? ~head_q : head_q;
        count_d = count_q + 2'(enq_fire) - 2'(deq_fire);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (enq_fire) entry_q[tail] <= enq_msg_i;
    end

endmodule

// File: rtl/lab4_sys_mem_net_router.sv
// N-to-1 16B memory request merge with round-robin arbitration and source tagging
// in opaque[7:6]; responses are steered back to the tagged port combinationally.
// Ports: cache2net_reqstream_* (N request streams in), cache2net_respstream_*
// (N response streams out), net2mem_reqstream_* (merged request out),
// net2mem_respstream_* (memory response in), clk, reset (async, active-low).
// Build option: LAB4_SYS_MEM_NET_ROUTER_INPUT_QUEUE_EN adds a 2-entry queue per port.
module lab4_sys_mem_net_router
    import lab4_sys_mem_net_router_pkg::*;
#(
    parameter int unsigned p_num_ports = 4
)(
    input  logic                   clk,
    input  logic                   reset,
    input  mem_req_16B_t           cache2net_reqstream_msg [p_num_ports],
    input  logic [p_num_ports-1:0] cache2net_reqstream_val,
    output logic [p_num_ports-1:0] cache2net_reqstream_rdy,
    output mem_resp_16B_t          cache2net_respstream_msg [p_num_ports],
    output logic [p_num_ports-1:0] cache2net_respstream_val,
    input  logic [p_num_ports-1:0] cache2net_respstream_rdy,
    output mem_req_16B_t           net2mem_reqstream_msg,
    output logic                   net2mem_reqstream_val,
    input  logic                   net2mem_reqstream_rdy,
    input  mem_resp_16B_t          net2mem_respstream_msg,
    input  logic                   net2mem_respstream_val,
    output logic                   net2mem_respstream_rdy
);

    mem_req_16B_t           arb_msg [p_num_ports];
    logic [p_num_ports-1:0] arb_val;
    logic [p_num_ports-1:0] arb_deq_rdy;
    logic [p_num_ports-1:0] grant;
    logic [SRC_ID_W-1:0]    grant_idx;
    logic                   grant_val;

    assign arb_deq_rdy = grant & {p_num_ports{net2mem_reqstream_rdy}};

`ifdef LAB4_SYS_MEM_NET_ROUTER_INPUT_QUEUE_EN
    logic [p_num_ports-1:0] q_enq_rdy;

    for (genvar i = 0; i < p_num_ports; i++) begin : g_queue
        lab4_sys_mem_net_router_queue u_queue (
            .clk         (clk),
            .reset       (reset),
            .enq_val_i   (cache2net_reqstream_val[i]),
            .enq_rdy_c_o (q_enq_rdy[i]),
            .enq_msg_i   (cache2net_reqstream_msg[i]),
            .deq_val_c_o (arb_val[i]),
            .deq_msg_c_o (arb_msg[i]),
            .deq_rdy_i   (arb_deq_rdy[i])
        );
    end

    assign cache2net_reqstream_rdy = q_enq_rdy & {p_num_ports{reset}};
`else
    assign arb_val                 = cache2net_reqstream_val;
    assign arb_msg                 = cache2net_reqstream_msg;
    assign cache2net_reqstream_rdy = arb_deq_rdy & {p_num_ports{reset}};
`endif

    lab4_sys_mem_net_rr_arb #(
        .p_num_ports (p_num_ports)
    ) u_arb (
        .clk           (clk),
        .reset         (reset),
        .val_i         (arb_val),
        .adv_i         (net2mem_reqstream_val & net2mem_reqstream_rdy),
        .grant_c_o     (grant),
        .grant_idx_c_o (grant_idx),
        .val_c_o       (grant_val)
    );

    assign net2mem_reqstream_val = grant_val & reset;
    assign net2mem_reqstream_msg = tag_req(arb_msg[grant_idx], grant_idx);

    // Response steering by source id; an out-of-range id is swallowed (rdy=1, no val)
    logic [SRC_ID_W-1:0] resp_dest;
    logic                resp_legal;
    logic                resp_dest_rdy;

    always_comb begin
        resp_dest                = net2mem_respstream_msg.opaque[SRC_ID_MSB:SRC_ID_LSB];
        resp_legal               = 1'b0;
        resp_dest_rdy            = 1'b1;
        cache2net_respstream_val = '0;
        for (int unsigned i = 0; i < p_num_ports; i++) begin
            cache2net_respstream_msg[i] = clear_src(net2mem_respstream_msg);
            if (resp_dest == SRC_ID_W'(i)) begin
                resp_legal                  = 1'b1;
                resp_dest_rdy               = cache2net_respstream_rdy[i];
                cache2net_respstream_val[i] = net2mem_respstream_val & reset;
            end
        end
        net2mem_respstream_rdy = resp_dest_rdy & reset;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && net2mem_respstream_val) begin
            assert (resp_legal)
            else $error("response source id %0d has no matching port", resp_dest);
        end
    end
`endif

endmodule

// File: tb/tb_lab4_sys_mem_net_router.sv
// Self-checking bench for lab4_sys_mem_net_router (default 4 ports).
module tb_lab4_sys_mem_net_router;
    import lab4_sys_mem_net_router_pkg::*;

    localparam int unsigned N = 4;

    logic          clk = 1'b0;
    logic          reset;
    mem_req_16B_t  c_req_msg [N];
    logic [N-1:0]  c_req_val, c_req_rdy;
    mem_resp_16B_t c_resp_msg [N];
    logic [N-1:0]  c_resp_val, c_resp_rdy;
    mem_req_16B_t  m_req_msg;
    logic          m_req_val, m_req_rdy;
    mem_resp_16B_t m_resp_msg;
    logic          m_resp_val, m_resp_rdy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    lab4_sys_mem_net_router #(.p_num_ports(N)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .cache2net_reqstream_msg  (c_req_msg),
        .cache2net_reqstream_val  (c_req_val),
        .cache2net_reqstream_rdy  (c_req_rdy),
        .cache2net_respstream_msg (c_resp_msg),
        .cache2net_respstream_val (c_resp_val),
        .cache2net_respstream_rdy (c_resp_rdy),
        .net2mem_reqstream_msg    (m_req_msg),
        .net2mem_reqstream_val    (m_req_val),
        .net2mem_reqstream_rdy    (m_req_rdy),
        .net2mem_respstream_msg   (m_resp_msg),
        .net2mem_respstream_val   (m_resp_val),
        .net2mem_respstream_rdy   (m_resp_rdy)
    );

    function automatic mem_req_16B_t rand_req();
        mem_req_16B_t r;
        r.msg_type = 3'($urandom_range(0, 1));
        r.opaque   = {2'b00, 6'($urandom)};
        r.addr     = $urandom;
        r.len      = 4'($urandom);
        r.data     = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    function automatic mem_req_16B_t exp_tag(input mem_req_16B_t m, input int idx);
        mem_req_16B_t r;
        r = m;
        r.opaque[7:6] = 2'(idx);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        c_req_val  = '0;
        c_resp_rdy = '0;
        m_req_rdy  = 1'b0;
        m_resp_val = 1'b0;
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset      = 1'b0;
        c_req_val  = 4'b1111;
        m_req_rdy  = 1'b1;
        m_resp_val = 1'b1;
        c_resp_rdy = 4'b1111;
        #1;
        checks++; if (m_req_val !== 1'b0) $display("FAIL reset_mem_val got %b want 0", m_req_val); else passed++;
        checks++; if (c_req_rdy !== 4'b0000) $display("FAIL reset_req_rdy got %b want 0000", c_req_rdy); else passed++;
        checks++; if (c_resp_val !== 4'b0000) $display("FAIL reset_resp_val got %b want 0000", c_resp_val); else passed++;
        checks++; if (m_resp_rdy !== 1'b0) $display("FAIL reset_resp_rdy got %b want 0", m_resp_rdy); else passed++;
        do_reset();
    endtask

    task automatic test_single_port();
        mem_resp_16B_t exp_r;
        do_reset();
        @(negedge clk);
        c_req_msg[2]        = rand_req();
        c_req_msg[2].msg_type = 3'd0;
        c_req_msg[2].addr   = 32'h0000_1000;
        c_req_msg[2].opaque = 8'h05;
        c_req_val           = 4'b0100;
        m_req_rdy           = 1'b1;
        #1;
        checks++; if (m_req_val !== 1'b1) $display("FAIL single_val got %b want 1", m_req_val); else passed++;
        checks++; if (m_req_msg.opaque !== 8'h85) $display("FAIL single_opaque got %h want 85", m_req_msg.opaque); else passed++;
        checks++; if (m_req_msg.addr !== 32'h1000) $display("FAIL single_addr got %h want 1000", m_req_msg.addr); else passed++;
        checks++; if (c_req_rdy !== 4'b0100) $display("FAIL single_rdy got %b want 0100", c_req_rdy); else passed++;
        @(negedge clk);
        c_req_val             = '0;
        m_resp_msg            = '0;
        m_resp_msg.opaque     = 8'h85;
        m_resp_msg.data       = {$urandom, $urandom, $urandom, $urandom};
        m_resp_val            = 1'b1;
        c_resp_rdy            = 4'b1111;
        exp_r                 = m_resp_msg;
        exp_r.opaque          = 8'h05;
        #1;
        checks++; if (c_resp_val !== 4'b0100) $display("FAIL single_resp_val got %b want 0100", c_resp_val); else passed++;
        checks++; if (c_resp_msg[2] !== exp_r) $display("FAIL single_resp_msg got %h want %h", c_resp_msg[2], exp_r); else passed++;
        checks++; if (m_resp_rdy !== 1'b1) $display("FAIL single_resp_rdy got %b want 1", m_resp_rdy); else passed++;
        @(negedge clk);
        m_resp_val = 1'b0;
    endtask

    task automatic test_fairness();
        int last;
        int g;
        do_reset();
        for (int i = 0; i < int'(N); i++) c_req_msg[i] = rand_req();
        last = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (last >= 0) c_req_msg[last] = rand_req();
            c_req_val = 4'b1111;
            m_req_rdy = 1'b1;
            #1;
            g = c % 4;
            checks++; if (c_req_rdy !== 4'(1 << g)) $display("FAIL fair_grant cyc%0d got %b want %b", c, c_req_rdy, 4'(1 << g)); else passed++;
            checks++; if (m_req_msg !== exp_tag(c_req_msg[g], g)) $display("FAIL fair_msg cyc%0d got %h want %h", c, m_req_msg, exp_tag(c_req_msg[g], g)); else passed++;
            last = g;
        end
        @(negedge clk);
        c_req_val = '0;
    endtask

    task automatic test_backpressure();
        mem_req_16B_t m1;
        do_reset();
        m1           = rand_req();
        c_req_msg[0] = rand_req();
        c_req_msg[1] = m1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            c_req_val = (c == 0) ? 4'b0010 : 4'b0011;
            m_req_rdy = 1'b0;
            #1;
            checks++; if (m_req_val !== 1'b1) $display("FAIL bp_val cyc%0d got %b want 1", c, m_req_val); else passed++;
            checks++; if (m_req_msg !== exp_tag(m1, 1)) $display("FAIL bp_hold_msg cyc%0d got %h want %h", c, m_req_msg, exp_tag(m1, 1)); else passed++;
            checks++; if (c_req_rdy !== 4'b0000) $display("FAIL bp_rdy cyc%0d got %b want 0000", c, c_req_rdy); else passed++;
        end
        @(negedge clk);
        m_req_rdy = 1'b1;
        #1;
        checks++; if (c_req_rdy !== 4'b0010) $display("FAIL bp_release got %b want 0010", c_req_rdy); else passed++;
        @(negedge clk);
        c_req_val = 4'b0001;
        #1;
        checks++; if (c_req_rdy !== 4'b0001) $display("FAIL bp_next_grant got %b want 0001", c_req_rdy); else passed++;
        checks++; if (m_req_msg !== exp_tag(c_req_msg[0], 0)) $display("FAIL bp_next_msg got %h want %h", m_req_msg, exp_tag(c_req_msg[0], 0)); else passed++;
        @(negedge clk);
        c_req_val = '0;
    endtask

    task automatic test_resp_backpressure();
        mem_resp_16B_t exp_r;
        @(negedge clk);
        m_resp_msg        = '0;
        m_resp_msg.data   = {$urandom, $urandom, $urandom, $urandom};
        m_resp_msg.opaque = {2'b11, 6'($urandom)};
        m_resp_val        = 1'b1;
        exp_r             = m_resp_msg;
        exp_r.opaque[7:6] = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            c_resp_rdy = 4'b0111;
            #1;
            checks++; if (m_resp_rdy !== 1'b0) $display("FAIL rbp_rdy cyc%0d got %b want 0", c, m_resp_rdy); else passed++;
            checks++; if (c_resp_val !== 4'b1000) $display("FAIL rbp_val cyc%0d got %b want 1000", c, c_resp_val); else passed++;
        end
        @(negedge clk);
        c_resp_rdy = 4'b1000;
        #1;
        checks++; if (m_resp_rdy !== 1'b1) $display("FAIL rbp_release got %b want 1", m_resp_rdy); else passed++;
        checks++; if (c_resp_msg[3] !== exp_r) $display("FAIL rbp_msg got %h want %h", c_resp_msg[3], exp_r); else passed++;
        @(negedge clk);
        m_resp_val = 1'b0;
    endtask

    task automatic test_resp_random();
        int            dest;
        logic [N-1:0]  rdy_v;
        mem_resp_16B_t exp_r;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            dest              = $urandom_range(0, N - 1);
            rdy_v             = 4'($urandom);
            m_resp_msg.msg_type = 3'($urandom);
            m_resp_msg.test   = 2'($urandom);
            m_resp_msg.len    = 4'($urandom);
            m_resp_msg.data   = {$urandom, $urandom, $urandom, $urandom};
            m_resp_msg.opaque = {2'(dest), 6'($urandom)};
            m_resp_val        = 1'($urandom);
            c_resp_rdy        = rdy_v;
            exp_r             = m_resp_msg;
            exp_r.opaque[7:6] = 2'b00;
            #1;
            checks++; if (c_resp_val !== (m_resp_val ? 4'(1 << dest) : 4'b0000)) $display("FAIL rresp_val cyc%0d got %b want %b", c, c_resp_val, (m_resp_val ? 4'(1 << dest) : 4'b0000)); else passed++;
            checks++; if (m_resp_rdy !== rdy_v[dest]) $display("FAIL rresp_rdy cyc%0d got %b want %b", c, m_resp_rdy, rdy_v[dest]); else passed++;
            checks++; if (c_resp_msg[dest] !== exp_r) $display("FAIL rresp_msg cyc%0d got %h want %h", c, c_resp_msg[dest], exp_r); else passed++;
        end
        @(negedge clk);
        m_resp_val = 1'b0;
        c_resp_rdy = '0;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        @(negedge clk);
        c_req_msg[3] = rand_req();
        c_req_val    = 4'b1000;
        m_req_rdy    = 1'b0;
        #1;
        checks++; if (m_req_msg !== exp_tag(c_req_msg[3], 3)) $display("FAIL rmh_grant3 got %h want %h", m_req_msg, exp_tag(c_req_msg[3], 3)); else passed++;
        @(negedge clk);
        m_resp_msg = '0;
        m_resp_val = 1'b1;
        c_resp_rdy = 4'b1111;
        #1 reset = 1'b0;
        #1;
        checks++; if (m_req_val !== 1'b0) $display("FAIL rmh_mem_val got %b want 0", m_req_val); else passed++;
        checks++; if (c_resp_val !== 4'b0000) $display("FAIL rmh_resp_val got %b want 0000", c_resp_val); else passed++;
        checks++; if (m_resp_rdy !== 1'b0) $display("FAIL rmh_resp_rdy got %b want 0", m_resp_rdy); else passed++;
        #1;
        reset        = 1'b1;
        m_resp_val   = 1'b0;
        c_req_msg[0] = rand_req();
        c_req_val    = 4'b1001;
        m_req_rdy    = 1'b1;
        #1;
        checks++; if (c_req_rdy !== 4'b0001) $display("FAIL rmh_restart got %b want 0001", c_req_rdy); else passed++;
        checks++; if (m_req_msg !== exp_tag(c_req_msg[0], 0)) $display("FAIL rmh_msg got %h want %h", m_req_msg, exp_tag(c_req_msg[0], 0)); else passed++;
        @(negedge clk);
        c_req_val = '0;
    endtask

    // Cache-side agents hold requests until accepted; model tracks pointer and held grant
    task automatic test_random_requests();
        int           mptr, mhold, g;
        bit           pend [N];
        bit           anyv;
        logic [N-1:0] exp_rdy;
        do_reset();
        mptr  = 0;
        mhold = -1;
        for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            for (int i = 0; i < int'(N); i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]      = 1'b1;
                    c_req_msg[i] = rand_req();
                end
                c_req_val[i] = pend[i];
            end
            m_req_rdy = ($urandom_range(0, 3) != 0);
            #1;
            anyv = 1'b0;
            g    = 0;
            if (mhold >= 0) begin
                anyv = pend[mhold];
                g    = mhold;
            end else begin
                for (int k = 0; k < int'(N); k++) begin
                    if (!anyv && pend[(mptr + k) % N]) begin
                        anyv = 1'b1;
                        g    = (mptr + k) % N;
                    end
                end
            end
            exp_rdy = (anyv && m_req_rdy) ? 4'(1 << g) : 4'b0000;
            checks++; if (m_req_val !== anyv) $display("FAIL rand_val cyc%0d got %b want %b", c, m_req_val, anyv); else passed++;
            checks++; if (c_req_rdy !== exp_rdy) $display("FAIL rand_rdy cyc%0d got %b want %b", c, c_req_rdy, exp_rdy); else passed++;
            if (anyv) begin
                checks++; if (m_req_msg !== exp_tag(c_req_msg[g], g)) $display("FAIL rand_msg cyc%0d got %h want %h", c, m_req_msg, exp_tag(c_req_msg[g], g)); else passed++;
            end
            if (anyv && m_req_rdy) begin
                pend[g] = 1'b0;
                mptr    = (g + 1) % N;
                mhold   = -1;
            end else if (anyv) begin
                mhold = g;
            end
        end
        @(negedge clk);
        c_req_val = '0;
    endtask

    task automatic test_queue();
        mem_req_16B_t a, b;
        do_reset();
        a = rand_req();
        b = rand_req();
        @(negedge clk);
        c_req_msg[0] = a;
        c_req_val    = 4'b0001;
        m_req_rdy    = 1'b0;
        #1;
        checks++; if (c_req_rdy[0] !== 1'b1) $display("FAIL q_push1_rdy got %b want 1", c_req_rdy[0]); else passed++;
        checks++; if (m_req_val !== 1'b0) $display("FAIL q_latency got %b want 0", m_req_val); else passed++;
        @(negedge clk);
        c_req_msg[0] = b;
        #1;
        checks++; if (c_req_rdy[0] !== 1'b1) $display("FAIL q_push2_rdy got %b want 1", c_req_rdy[0]); else passed++;
        @(negedge clk);
        c_req_msg[0] = rand_req();
        #1;
        checks++; if (c_req_rdy[0] !== 1'b0) $display("FAIL q_full_rdy got %b want 0", c_req_rdy[0]); else passed++;
        @(negedge clk);
        c_req_val = '0;
        m_req_rdy = 1'b1;
        #1;
        checks++; if (m_req_msg !== exp_tag(a, 0)) $display("FAIL q_first got %h want %h", m_req_msg, exp_tag(a, 0)); else passed++;
        @(negedge clk);
        #1;
        checks++; if (m_req_msg !== exp_tag(b, 0)) $display("FAIL q_second got %h want %h", m_req_msg, exp_tag(b, 0)); else passed++;
        checks++; if (m_req_val !== 1'b1) $display("FAIL q_second_val got %b want 1", m_req_val); else passed++;
        @(negedge clk);
        #1;
        checks++; if (m_req_val !== 1'b0) $display("FAIL q_drained got %b want 0", m_req_val); else passed++;
    endtask

    initial begin
        reset      = 1'b0;
        c_req_val  = '0;
        c_resp_rdy = '0;
        m_req_rdy  = 1'b0;
        m_resp_val = 1'b0;
        m_resp_msg = '0;
        for (int i = 0; i < int'(N); i++) c_req_msg[i] = '0;
        test_reset();
`ifdef LAB4_SYS_MEM_NET_ROUTER_INPUT_QUEUE_EN
        test_queue();
`else
        test_single_port();
        test_fairness();
        test_backpressure();
        test_reset_mid_hold();
        test_random_requests();
`endif
        test_resp_backpressure();
        test_resp_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
